cmp_result_tracker: RTL and testbench

Sequential stage directly downstream of the 2-bit magnitude comparator. Each cycle it may accept one comparator verdict (F1 = AB>CD, F2 = AB<CD, F3 = AB==CD) qualified by a valid strobe. It keeps saturating tallies of greater, less and equal verdicts and detects a run of consecutive equal verdicts ("lock"). It flags any verdict that is not one-hot as a sticky error, so the comparator's output can be monitored over a long operand stream.

---
 rtl/cmp_result_tracker_if.sv | 28 ++
 rtl/cmp_result_tracker.sv | 92 +++++++++
 tb/tb_cmp_result_tracker.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cmp_result_tracker_if.sv
// Verdict bus between the 2-bit comparator stream source and cmp_result_tracker.
// The master drives verdicts and clear. The slave (the tracker) returns tallies and status.
interface cmp_result_tracker_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             f1;
  logic             f2;
  logic             f3;
  logic             clr;
  logic [CNT_W-1:0] gt_cnt;
  logic [CNT_W-1:0] lt_cnt;
  logic [CNT_W-1:0] eq_cnt;
  logic [3:0]       run_cnt;
  logic [1:0]       last_code;
  logic             lock;
  logic             err;

  modport master (
    output in_valid, f1, f2, f3, clr,
    input  gt_cnt, lt_cnt, eq_cnt, run_cnt, last_code, lock, err
  );

  modport slave (
    input  in_valid, f1, f2, f3, clr,
    output gt_cnt, lt_cnt, eq_cnt, run_cnt, last_code, lock, err
  );
endinterface

// File: rtl/cmp_result_tracker.sv
// Tracks comparator verdicts with saturating tallies and equal-run lock detection.
// Any verdict that is not one-hot raises a sticky error until clr or rst.
module cmp_result_tracker #(
  parameter int CNT_W   = 8,
  parameter int RUN_LEN = 3
) (
  input logic                  clk,
  input logic                  rst,
  cmp_result_tracker_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_LOCKED, S_ERROR} state_t;

  localparam logic [3:0]       RUN_MAX = 4'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_run;
  logic [3:0]       w_run_nxt;
  logic [3:0]       w_run_inc;
  logic [CNT_W-1:0] r_gt;
  logic [CNT_W-1:0] r_lt;
  logic [CNT_W-1:0] r_eq;
  logic [1:0]       r_last;
  logic             w_legal;
  logic             w_sample;
  logic             w_take;

  assign w_legal   = (bus.f1 & ~bus.f2 & ~bus.f3) |
                     (~bus.f1 & bus.f2 & ~bus.f3) |
                     (~bus.f1 & ~bus.f2 & bus.f3);
  // ERROR freezes everything, so samples there are ignored outright.
  assign w_sample  = bus.in_valid & ~bus.clr & (r_state != S_ERROR);
  assign w_take    = w_sample & w_legal;
  assign w_run_inc = r_run + 4'd1;

  // NOTE: every output of this block gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    if (bus.clr) begin
      w_state_nxt = S_IDLE;
      w_run_nxt   = 4'd0;
    end else if (w_sample) begin
      if (!w_legal) begin
        w_state_nxt = S_ERROR;
      end else if (bus.f3) begin
        if (r_state != S_LOCKED) begin
          w_run_nxt   = w_run_inc;
          w_state_nxt = (w_run_inc == RUN_MAX) ? S_LOCKED : S_TRACK;
        end
      end else begin
        w_run_nxt   = 4'd0;
        w_state_nxt = S_TRACK;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_run   <= 4'd0;
      r_gt    <= '0;
      r_lt    <= '0;
      r_eq    <= '0;
      r_last  <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
      if (bus.clr) begin
        r_gt   <= '0;
        r_lt   <= '0;
        r_eq   <= '0;
        r_last <= 2'b00;
      end else if (w_take) begin
        if (bus.f1 && r_gt != CNT_MAX) r_gt <= r_gt + CNT_W'(1);
        if (bus.f2 && r_lt != CNT_MAX) r_lt <= r_lt + CNT_W'(1);
        if (bus.f3 && r_eq != CNT_MAX) r_eq <= r_eq + CNT_W'(1);
        r_last <= {bus.f2 | bus.f3, bus.f1 | bus.f3};
      end
    end
  end

  assign bus.gt_cnt    = r_gt;
  assign bus.lt_cnt    = r_lt;
  assign bus.eq_cnt    = r_eq;
  assign bus.run_cnt   = r_run;
  assign bus.last_code = r_last;
  assign bus.lock      = (r_state == S_LOCKED);
  assign bus.err       = (r_state == S_ERROR);
endmodule

// File: tb/tb_cmp_result_tracker.sv
// Bench for cmp_result_tracker: directed scenarios with literal expectations,
// then a random verdict stream compared every cycle against a behavioural model.
module tb_cmp_result_tracker;
  localparam int CNT_W   = 4;
  localparam int RUN_LEN = 3;
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam logic [2:0] GT = 3'b100, LT = 3'b010, EQ = 3'b001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  cmp_result_tracker_if #(.CNT_W(CNT_W)) bus ();

  cmp_result_tracker #(.CNT_W(CNT_W), .RUN_LEN(RUN_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: counts, run length and a sticky error flag.
  int m_gt = 0, m_lt = 0, m_eq = 0, m_run = 0, m_last = 0;
  bit m_err = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst || bus.clr) begin
      m_gt <= 0; m_lt <= 0; m_eq <= 0; m_run <= 0; m_last <= 0; m_err <= 1'b0;
    end else if (bus.in_valid && !m_err) begin
      if ($countones({bus.f1, bus.f2, bus.f3}) != 1) begin
        m_err <= 1'b1;
      end else if (bus.f1) begin
        m_gt <= (m_gt < CMAX) ? m_gt + 1 : m_gt; m_last <= 1; m_run <= 0;
      end else if (bus.f2) begin
        m_lt <= (m_lt < CMAX) ? m_lt + 1 : m_lt; m_last <= 2; m_run <= 0;
      end else begin
        m_eq <= (m_eq < CMAX) ? m_eq + 1 : m_eq; m_last <= 3;
        m_run <= (m_run < RUN_LEN) ? m_run + 1 : m_run;
      end
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("m.gt_cnt", int'(bus.gt_cnt), m_gt);
      check("m.lt_cnt", int'(bus.lt_cnt), m_lt);
      check("m.eq_cnt", int'(bus.eq_cnt), m_eq);
      check("m.run_cnt", int'(bus.run_cnt), m_run);
      check("m.last_code", int'(bus.last_code), m_last);
      check("m.err", int'(bus.err), int'(m_err));
      check("m.lock", int'(bus.lock), int'(!m_err && m_run == RUN_LEN));
    end
  end

  // Apply one cycle of stimulus; returns 2 time units after the sampling edge.
  task automatic step(input logic v, input logic [2:0] f, input logic c);
    bus.in_valid = v;
    {bus.f1, bus.f2, bus.f3} = f;
    bus.clr = c;
    @(posedge clk);
    #2;
  endtask

  task automatic check_all(input string tag, input int gt, input int lt, input int eq,
                           input int run, input int last, input int lock, input int err);
    check({tag, ".gt_cnt"}, int'(bus.gt_cnt), gt);
    check({tag, ".lt_cnt"}, int'(bus.lt_cnt), lt);
    check({tag, ".eq_cnt"}, int'(bus.eq_cnt), eq);
    check({tag, ".run_cnt"}, int'(bus.run_cnt), run);
    check({tag, ".last_code"}, int'(bus.last_code), last);
    check({tag, ".lock"}, int'(bus.lock), lock);
    check({tag, ".err"}, int'(bus.err), err);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    {bus.f1, bus.f2, bus.f3} = 3'b000;
    bus.clr = 1'b0;
    #2;
    check_all("reset", 0, 0, 0, 0, 0, 0, 0);
    #10 rst = 1'b0;

    // gt, lt, eq stream
    step(1, GT, 0); step(1, LT, 0); step(1, EQ, 0);
    check_all("mix", 1, 1, 1, 1, 3, 0, 0);

    // four eq then gt
    step(0, 3'b000, 1);
    step(1, EQ, 0); step(1, EQ, 0); step(1, EQ, 0);
    check_all("eq3", 0, 0, 3, 3, 3, 1, 0);
    step(1, EQ, 0);
    check_all("eq4", 0, 0, 4, 3, 3, 1, 0);
    step(1, GT, 0);
    check_all("unlock", 1, 0, 4, 0, 1, 0, 0);

    // saturation
    step(0, 3'b000, 1);
    for (int i = 0; i < 20; i++) step(1, GT, 0);
    check_all("sat", CMAX, 0, 0, 0, 1, 0, 0);

    // illegal verdict and freeze
    step(0, 3'b000, 1);
    step(1, EQ, 0); step(1, EQ, 0); step(1, 3'b110, 0);
    check_all("illegal", 0, 0, 2, 2, 3, 0, 1);
    step(1, GT, 0); step(1, EQ, 0); step(1, LT, 0); step(1, EQ, 0); step(1, EQ, 0);
    check_all("frozen", 0, 0, 2, 2, 3, 0, 1);
    step(0, 3'b000, 1);
    check_all("clr", 0, 0, 0, 0, 0, 0, 0);

    // idle cycle does not break the run; clr beats a sample
    step(1, EQ, 0); step(0, EQ, 0); step(1, EQ, 0);
    check_all("gap", 0, 0, 2, 2, 3, 0, 0);
    step(1, GT, 1);
    check_all("clr_wins", 0, 0, 0, 0, 0, 0, 0);

    // async reset from LOCKED, checked before the next edge
    step(1, EQ, 0); step(1, EQ, 0); step(1, EQ, 0);
    check("pre_rst.lock", int'(bus.lock), 1);
    bus.in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    @(posedge clk); #2;

    // random stream
    for (int i = 0; i < 3000; i++) begin
      logic       v, c;
      logic [2:0] f;
      int         r;
      v = ($urandom_range(0, 99) < 80);
      c = ($urandom_range(0, 99) < 2);
      r = $urandom_range(0, 99);
      if (r < 25)      f = GT;
      else if (r < 45) f = LT;
      else if (r < 96) f = EQ;
      else             f = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
      step(v, f, c);
    end

    step(0, 3'b000, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
